// File: rtl/mmio_print_unit.sv
// rtl/mmio_print_unit.sv - MMIO console: hex/string print commands streamed as ASCII bytes
// Sits on the CPU bus in front of RAM port A and fetches string words through RAM port B.
module mmio_print_unit #(
  parameter logic [15:0] INT_ADDR  = 16'h1000,
  parameter logic [15:0] STR_ADDR  = 16'h1002,
  parameter logic [15:0] STAT_ADDR = 16'h1004,
  parameter int          MAX_LEN   = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [15:0] i_cpu_wrdata,
  output logic [15:0] o_cpu_rddata,
  output logic        o_mem_wr,
  input  logic [15:0] i_mem_rddata,
  output logic [15:0] o_memb_addr,
  output logic        o_memb_rd,
  input  logic [15:0] i_memb_rddata,
  output logic [7:0]  o_char,
  output logic        o_char_valid,
  input  logic        i_char_ready,
  output logic        o_busy
);

  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_HEX, S_FETCH, S_WAIT, S_EMIT, S_EOL} state_t;

  state_t        state;
  logic [15:0]   hex_data;
  logic [15:0]   ptr;
  logic [1:0]    idx;
  logic [CW-1:0] count;
  logic          trunc;
  logic          overrun;
  logic          stat_sel;

  logic mmio_hit, int_wr, str_wr, stat_wr, handshake;

  assign int_wr    = i_cpu_wr && (i_cpu_addr == INT_ADDR);
  assign str_wr    = i_cpu_wr && (i_cpu_addr == STR_ADDR);
  assign stat_wr   = i_cpu_wr && (i_cpu_addr == STAT_ADDR);
  assign mmio_hit  = (i_cpu_addr == INT_ADDR) || (i_cpu_addr == STR_ADDR) ||
                     (i_cpu_addr == STAT_ADDR);
  assign handshake = o_char_valid && i_char_ready;

  assign o_mem_wr     = i_cpu_wr && !mmio_hit;
  assign o_cpu_rddata = stat_sel ? {13'b0, overrun, trunc, o_busy} : i_mem_rddata;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nibble(input logic [15:0] d, input logic [1:0] i);
    case (i)
      2'd3:    return d[15:12];
      2'd2:    return d[11:8];
      2'd1:    return d[7:4];
      default: return d[3:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      hex_data     <= '0;
      ptr          <= '0;
      idx          <= '0;
      count        <= '0;
      trunc        <= 1'b0;
      overrun      <= 1'b0;
      stat_sel     <= 1'b0;
      o_char       <= '0;
      o_char_valid <= 1'b0;
      o_memb_rd    <= 1'b0;
      o_memb_addr  <= '0;
      o_busy       <= 1'b0;
    end else begin
      stat_sel <= i_cpu_rd && (i_cpu_addr == STAT_ADDR);

      // Clear first so a same-cycle set below takes priority
      if (stat_wr) begin
        trunc   <= 1'b0;
        overrun <= 1'b0;
      end
      if ((int_wr || str_wr) && state != S_IDLE)
        overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (int_wr) begin
            hex_data     <= i_cpu_wrdata;
            idx          <= 2'd3;
            o_char       <= hex_char(i_cpu_wrdata[15:12]);
            o_char_valid <= 1'b1;
            o_busy       <= 1'b1;
            state        <= S_HEX;
          end else if (str_wr) begin
            ptr    <= i_cpu_wrdata & 16'hFFFE;
            count  <= '0;
            o_busy <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_HEX: begin
          if (handshake) begin
            if (idx == 2'd0) begin
              o_char <= 8'h0A;
              state  <= S_EOL;
            end else begin
              idx    <= idx - 2'd1;
              o_char <= hex_char(nibble(hex_data, idx - 2'd1));
            end
          end
        end
        S_FETCH: begin
          if (count == CW'(MAX_LEN)) begin
            trunc        <= 1'b1;
            o_char       <= 8'h0A;
            o_char_valid <= 1'b1;
            state        <= S_EOL;
          end else begin
            o_memb_rd   <= 1'b1;
            o_memb_addr <= ptr;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // First WAIT cycle carries the read strobe; RAM data lands in the next one
          if (o_memb_rd) begin
            o_memb_rd <= 1'b0;
          end else if (i_memb_rddata == 16'h0000) begin
            o_char       <= 8'h0A;
            o_char_valid <= 1'b1;
            state        <= S_EOL;
          end else begin
            o_char       <= i_memb_rddata[7:0];
            o_char_valid <= 1'b1;
            state        <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (handshake) begin
            o_char_valid <= 1'b0;
            ptr          <= ptr + 16'd2;
            count        <= count + CW'(1);
            state        <= S_FETCH;
          end
        end
        S_EOL: begin
          if (handshake) begin
            o_char_valid <= 1'b0;
            o_busy       <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_print_unit.sv
// tb/tb_mmio_print_unit.sv - directed scoreboard bench for mmio_print_unit
module tb_mmio_print_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] i_cpu_addr = '0;
  logic        i_cpu_rd = 1'b0;
  logic        i_cpu_wr = 1'b0;
  logic [15:0] i_cpu_wrdata = '0;
  logic [15:0] o_cpu_rddata;
  logic        o_mem_wr;
  logic [15:0] i_mem_rddata = '0;
  logic [15:0] o_memb_addr;
  logic        o_memb_rd;
  logic [15:0] i_memb_rddata = '0;
  logic [7:0]  o_char;
  logic        o_char_valid;
  logic        i_char_ready = 1'b1;
  logic        o_busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  sb[$];
  logic [15:0] ab[$];
  logic [15:0] ram [0:32767];

  mmio_print_unit #(.MAX_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .i_cpu_addr(i_cpu_addr), .i_cpu_rd(i_cpu_rd), .i_cpu_wr(i_cpu_wr),
    .i_cpu_wrdata(i_cpu_wrdata), .o_cpu_rddata(o_cpu_rddata), .o_mem_wr(o_mem_wr),
    .i_mem_rddata(i_mem_rddata), .o_memb_addr(o_memb_addr), .o_memb_rd(o_memb_rd),
    .i_memb_rddata(i_memb_rddata), .o_char(o_char), .o_char_valid(o_char_valid),
    .i_char_ready(i_char_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Port B RAM: data valid the cycle after the strobe
  always @(posedge clk)
    if (o_memb_rd) i_memb_rddata <= ram[o_memb_addr[15:1]];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input logic exp_wr);
    i_cpu_addr   = a;
    i_cpu_wrdata = d;
    i_cpu_wr     = 1'b1;
    #1;
    check("mem_wr", {15'b0, o_mem_wr}, {15'b0, exp_wr});
    @(posedge clk);
    #1;
    i_cpu_wr = 1'b0;
  endtask

  task automatic read_status(input string tag, input logic [15:0] exp);
    i_cpu_addr = 16'h1004;
    i_cpu_rd   = 1'b1;
    tick;
    i_cpu_rd   = 1'b0;
    check(tag, o_cpu_rddata, exp);
  endtask

  task automatic drain(input int maxc, input logic [7:0] stall_ch, input int stall_n);
    int stalls;
    stalls = stall_n;
    for (int c = 0; c < maxc && sb.size() > 0; c++) begin
      if (o_memb_rd) begin
        if (ab.size() > 0) check("memb_addr", o_memb_addr, ab.pop_front());
        else check("memb_rd_unexpected", {15'b0, o_memb_rd}, 16'h0000);
      end
      if (o_char_valid && sb[0] == stall_ch && stalls > 0) begin
        i_char_ready = 1'b0;
        check("stall_char_stable", {8'h0, o_char}, {8'h0, sb[0]});
        check("stall_no_memb_rd", {15'b0, o_memb_rd}, 16'h0000);
        stalls--;
      end else begin
        i_char_ready = 1'b1;
        if (o_char_valid) check("char", {8'h0, o_char}, {8'h0, sb.pop_front()});
      end
      tick;
    end
    if (sb.size() > 0) check("chars_timeout", 16'(sb.size()), 16'h0000);
    if (ab.size() > 0) check("memb_reads_missing", 16'(ab.size()), 16'h0000);
    sb.delete();
    ab.delete();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;

    // Reset state
    repeat (3) tick;
    check("rst_valid", {15'b0, o_char_valid}, 16'h0000);
    check("rst_char", {8'h0, o_char}, 16'h0000);
    check("rst_memb_rd", {15'b0, o_memb_rd}, 16'h0000);
    check("rst_memb_addr", o_memb_addr, 16'h0000);
    check("rst_busy", {15'b0, o_busy}, 16'h0000);
    reset = 1'b1;
    tick;
    read_status("rst_status", 16'h0000);

    // Hex print
    sb.push_back("b"); sb.push_back("e"); sb.push_back("e"); sb.push_back("f");
    sb.push_back(8'h0A);
    cpu_write(16'h1000, 16'hBEEF, 1'b0);
    drain(40, 8'h00, 0);
    check("hex_busy_done", {15'b0, o_busy}, 16'h0000);

    // String print
    ram[16'h0100] = 16'h0048; ram[16'h0101] = 16'h0069; ram[16'h0102] = 16'h0000;
    ab.push_back(16'h0200); ab.push_back(16'h0202); ab.push_back(16'h0204);
    sb.push_back("H"); sb.push_back("i"); sb.push_back(8'h0A);
    cpu_write(16'h1002, 16'h0200, 1'b0);
    drain(60, 8'h00, 0);
    check("str_busy_done", {15'b0, o_busy}, 16'h0000);

    // Backpressure on 'i', odd pointer masked to even
    ab.push_back(16'h0200); ab.push_back(16'h0202); ab.push_back(16'h0204);
    sb.push_back("H"); sb.push_back("i"); sb.push_back(8'h0A);
    cpu_write(16'h1002, 16'h0201, 1'b0);
    drain(60, "i", 3);

    // Truncation at MAX_LEN=4, sticky clear
    for (int i = 0; i < 5; i++) ram[16'h0200 + i] = 16'h0061 + 16'(i);
    for (int i = 0; i < 4; i++) ab.push_back(16'h0400 + 16'(2 * i));
    sb.push_back("a"); sb.push_back("b"); sb.push_back("c"); sb.push_back("d");
    sb.push_back(8'h0A);
    cpu_write(16'h1002, 16'h0400, 1'b0);
    drain(80, 8'h00, 0);
    read_status("trunc_status", 16'h0002);
    cpu_write(16'h1004, 16'hFFFF, 1'b0);
    read_status("trunc_cleared", 16'h0000);

    // Overrun while busy, port A pass-through
    i_char_ready = 1'b0;
    cpu_write(16'h1002, 16'h0200, 1'b0);
    cpu_write(16'h1002, 16'h0300, 1'b0);
    read_status("overrun_busy_status", 16'h0005);
    cpu_write(16'h0300, 16'h1234, 1'b1);
    i_mem_rddata = 16'hA5A5;
    i_cpu_addr   = 16'h0300;
    i_cpu_rd     = 1'b1;
    tick;
    i_cpu_rd = 1'b0;
    check("porta_rddata", o_cpu_rddata, 16'hA5A5);
    ab.push_back(16'h0202); ab.push_back(16'h0204);
    sb.push_back("H"); sb.push_back("i"); sb.push_back(8'h0A);
    drain(60, 8'h00, 0);
    read_status("overrun_idle_status", 16'h0004);
    cpu_write(16'h1004, 16'h0000, 1'b0);
    read_status("overrun_cleared", 16'h0000);

    // Pointer wrap 0xFFFE -> 0x0000
    ram[16'h7FFF] = 16'h0041; ram[16'h0000] = 16'h0000;
    ab.push_back(16'hFFFE); ab.push_back(16'h0000);
    sb.push_back("A"); sb.push_back(8'h0A);
    cpu_write(16'h1002, 16'hFFFE, 1'b0);
    drain(40, 8'h00, 0);

    // Reset mid-EMIT
    i_char_ready = 1'b0;
    cpu_write(16'h1002, 16'hFFFE, 1'b0);
    for (int c = 0; c < 20 && !o_char_valid; c++) tick;
    check("emit_reached", {15'b0, o_char_valid}, 16'h0001);
    reset = 1'b0;
    tick;
    check("midrst_valid", {15'b0, o_char_valid}, 16'h0000);
    check("midrst_busy", {15'b0, o_busy}, 16'h0000);
    check("midrst_memb_rd", {15'b0, o_memb_rd}, 16'h0000);
    reset = 1'b1;
    i_char_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      check("postrst_no_char", {15'b0, o_char_valid}, 16'h0000);
    end
    read_status("postrst_status", 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
